// File: rtl/sound_scheduler_pkg.sv
// Shared sound definitions: command codes, default timings and scheduler
// state encoding. Also imported by the piezo driver so both sides agree
// on what each command code means and how long it plays.
package sound_scheduler_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_PERF = 2'd1,
    CMD_GOOD = 2'd2,
    CMD_MISS = 2'd3
  } sound_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_PLAY,
    ST_GAP
  } sched_state_t;

  // Default play lengths in 50 MHz cycles (120 ms, 90 ms, 160 ms, 5 ms gap)
  localparam int unsigned DEF_DUR_PERF = 6_000_000;
  localparam int unsigned DEF_DUR_GOOD = 4_500_000;
  localparam int unsigned DEF_DUR_MISS = 8_000_000;
  localparam int unsigned DEF_GAP_CYC  = 250_000;

  // Timer is wide enough for the longest sound (DUR_MISS)
  localparam int TIMER_W    = 23;
  localparam int NUM_LANES  = 4;
  localparam int FIFO_DEPTH = 4;

  // Extract the 2-bit command of one lane from the packed request bus
  function automatic logic [1:0] lane_cmd(input logic [7:0] cmds, input logic [1:0] lane);
    return cmds[{lane, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Four-entry FIFO of pending sound commands. Flush has priority over push
// and pop so a mute always leaves the queue empty; a push into a full
// queue is only accepted when an entry is popped in the same cycle.
module sound_cmd_fifo
  import sound_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] data_in,
  output logic [1:0] data_out,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  logic [1:0] mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign empty    = (count == 3'd0);
  assign full     = (count == 3'(FIFO_DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/sound_scheduler.sv
// Sound scheduler: round-robin arbiter over four request lanes feeding a
// small command FIFO, and a sequencer that issues one command at a time to
// the piezo driver, holding off for the sound's play time plus a gap.
module sound_scheduler
  import sound_scheduler_pkg::*;
#(
  parameter int unsigned DUR_PERF = DEF_DUR_PERF,
  parameter int unsigned DUR_GOOD = DEF_DUR_GOOD,
  parameter int unsigned DUR_MISS = DEF_DUR_MISS,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Req,
  input  logic [7:0] i_Req_Cmd,
  input  logic       i_Mute,
  output logic [3:0] o_Ack,
  output logic [1:0] o_Sound_Cmd,
  output logic       o_Busy,
  output logic [2:0] o_Fifo_Cnt,
  output logic [7:0] o_Drop_Cnt
);

  // Timer reload values: the timer counts down to zero inclusive
  localparam logic [TIMER_W-1:0] PERF_LOAD = TIMER_W'(DUR_PERF - 1);
  localparam logic [TIMER_W-1:0] GOOD_LOAD = TIMER_W'(DUR_GOOD - 1);
  localparam logic [TIMER_W-1:0] MISS_LOAD = TIMER_W'(DUR_MISS - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = (GAP_CYC == 0) ? '0 : TIMER_W'(GAP_CYC - 1);

  sched_state_t       state;
  sched_state_t       next_state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [1:0]         rr_ptr;
  logic [1:0]         search_idx;
  logic [1:0]         winner;
  logic               grant_valid;
  logic [3:0]         grant;
  logic [3:0]         eligible;
  logic [1:0]         win_cmd;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_head;
  logic [2:0]         fifo_count;
  logic               drop_event;

  // A lane competes only when it requests and carries a real command
  always_comb begin
    eligible = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      eligible[n] = i_Req[n] && (lane_cmd(i_Req_Cmd, 2'(n)) != 2'(CMD_NONE));
    end
  end

  // Round-robin search starting at rr_ptr, first eligible lane wins
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    winner      = rr_ptr;
    search_idx  = rr_ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      search_idx = rr_ptr + 2'(i);
      if (!grant_valid && eligible[search_idx]) begin
        grant_valid = 1'b1;
        winner      = search_idx;
      end
    end
    if (grant_valid) grant[winner] = 1'b1;
  end

  assign o_Ack      = i_Rst ? 4'b0000 : grant;
  assign win_cmd    = lane_cmd(i_Req_Cmd, winner);
  assign fifo_pop   = (state == ST_ISSUE);
  assign fifo_push  = grant_valid && !i_Mute;
  assign drop_event = grant_valid && !i_Mute && fifo_full && !fifo_pop;
  assign o_Fifo_Cnt = fifo_count;

  sound_cmd_fifo u_fifo (
    .clk      (i_Clk),
    .rst      (i_Rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (i_Mute),
    .data_in  (win_cmd),
    .data_out (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sequencer next-state and timer: issue one cycle, play, optional gap
  always_comb begin
    next_state = state;
    timer_next = timer;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !i_Mute) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        case (fifo_head)
          CMD_PERF: timer_next = PERF_LOAD;
          CMD_GOOD: timer_next = GOOD_LOAD;
          CMD_MISS: timer_next = MISS_LOAD;
          default:  timer_next = PERF_LOAD;
        endcase
        next_state = ST_PLAY;
      end
      ST_PLAY: begin
        if (timer == '0) begin
          if (GAP_CYC == 0) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_GAP;
            timer_next = GAP_LOAD;
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer == '0) next_state = ST_IDLE;
        else             timer_next = timer - 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, timer and registered outputs; sound command is a one-cycle pulse
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      o_Sound_Cmd <= 2'(CMD_NONE);
      o_Busy      <= 1'b0;
    end else begin
      state       <= next_state;
      timer       <= timer_next;
      o_Sound_Cmd <= (next_state == ST_ISSUE) ? fifo_head : 2'(CMD_NONE);
      o_Busy      <= (next_state != ST_IDLE);
    end
  end

  // Fairness pointer moves past the winner on every grant
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)            rr_ptr <= '0;
    else if (grant_valid) rr_ptr <= winner + 2'd1;
  end

  // Saturating count of granted commands lost to a full queue
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                                  o_Drop_Cnt <= '0;
    else if (drop_event && o_Drop_Cnt != 8'hFF) o_Drop_Cnt <= o_Drop_Cnt + 8'd1;
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Testbench for sound_scheduler: lanes hold requests until acked, a
// behavioural model predicts acks, queue depth, drops and when each sound
// must appear; a separate monitor checks every emitted sound against the
// expected-sound queue.
module tb_sound_scheduler;

  localparam int DP = 12;
  localparam int DG = 9;
  localparam int DM = 16;
  localparam int GP = 3;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [3:0] i_Req = '0;
  logic [7:0] i_Req_Cmd = '0;
  logic       i_Mute = 1'b0;
  logic [3:0] o_Ack;
  logic [1:0] o_Sound_Cmd;
  logic       o_Busy;
  logic [2:0] o_Fifo_Cnt;
  logic [7:0] o_Drop_Cnt;

  sound_scheduler #(
    .DUR_PERF (DP),
    .DUR_GOOD (DG),
    .DUR_MISS (DM),
    .GAP_CYC  (GP)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Req       (i_Req),
    .i_Req_Cmd   (i_Req_Cmd),
    .i_Mute      (i_Mute),
    .o_Ack       (o_Ack),
    .o_Sound_Cmd (o_Sound_Cmd),
    .o_Busy      (o_Busy),
    .o_Fifo_Cnt  (o_Fifo_Cnt),
    .o_Drop_Cnt  (o_Drop_Cnt)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int cmd;
    int cyc;
  } sound_t;

  sound_t sb[$];
  sound_t mon_s;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Lane side: a lane keeps its request up until it sees its ack
  logic [3:0] pend = '0;
  int pcmd[4];

  // Reference model: queue contents, fairness pointer, drop count and the
  // time window in which the sequencer is occupied by the current sound
  int mq[$];
  int mptr = 0;
  int mdrop = 0;
  int free_at = 0;
  int last_issue = 0;
  int issue_cycle = -1;

  function automatic int durOf(input int c);
    case (c)
      1: return DP;
      2: return DG;
      default: return DM;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic raise(input int lane, input int c);
    pend[lane] = 1'b1;
    pcmd[lane] = c;
  endtask

  task automatic modelReset();
    mq.delete();
    sb.delete();
    mptr = 0;
    mdrop = 0;
    free_at = 0;
    last_issue = 0;
    issue_cycle = -1;
    pend = '0;
  endtask

  // Predict this cycle's outputs, compare, then advance the model
  task automatic modelCycle();
    int winner;
    bit popping;
    int lane;
    winner = -1;
    popping = (issue_cycle == cyc);
    for (int k = 0; k < 4; k++) begin
      lane = (mptr + k) % 4;
      if (winner < 0 && pend[lane] && pcmd[lane] != 0) winner = lane;
    end
    checkOutput("ack", int'(o_Ack), (winner < 0) ? 0 : (1 << winner));
    checkOutput("busy", int'(o_Busy), int'(cyc >= last_issue && cyc < free_at));
    checkOutput("fifo_cnt", int'(o_Fifo_Cnt), mq.size());
    checkOutput("drop_cnt", int'(o_Drop_Cnt), mdrop);
    if (cyc >= free_at && mq.size() > 0 && !i_Mute) begin
      sb.push_back('{mq[0], cyc + 1});
      issue_cycle = cyc + 1;
      last_issue  = cyc + 1;
      free_at     = cyc + 2 + durOf(mq[0]) + GP;
    end
    if (popping) void'(mq.pop_front());
    if (winner >= 0) begin
      mptr = (winner + 1) % 4;
      if (!i_Mute) begin
        if (mq.size() < 4) mq.push_back(pcmd[winner]);
        else if (mdrop < 255) mdrop++;
      end
      pend[winner] = 1'b0;
    end
    if (i_Mute) mq.delete();
  endtask

  task automatic applyStimulus(input logic mute);
    @(negedge i_Clk);
    cyc++;
    for (int l = 0; l < 4; l++) begin
      i_Req[l] = pend[l];
      i_Req_Cmd[2*l +: 2] = 2'(pcmd[l]);
    end
    i_Mute = mute;
    #1;
    modelCycle();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0);
  endtask

  task automatic runRandom(input int n, input int rate, input int mute_pct);
    logic m;
    repeat (n) begin
      for (int l = 0; l < 4; l++) begin
        if (!pend[l] && $urandom_range(99) < rate) raise(l, int'($urandom_range(3, 1)));
      end
      m = ($urandom_range(99) < mute_pct);
      applyStimulus(m);
    end
  endtask

  // Assert reset mid-cycle with live requests; everything must clear at once
  task automatic doReset();
    @(negedge i_Clk);
    #3;
    i_Req = 4'hF;
    i_Req_Cmd = 8'hFF;
    i_Rst = 1'b1;
    #1;
    checkOutput("rst_ack", int'(o_Ack), 0);
    checkOutput("rst_sound", int'(o_Sound_Cmd), 0);
    checkOutput("rst_busy", int'(o_Busy), 0);
    checkOutput("rst_fifo_cnt", int'(o_Fifo_Cnt), 0);
    checkOutput("rst_drop_cnt", int'(o_Drop_Cnt), 0);
    modelReset();
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Req = '0;
    i_Req_Cmd = '0;
    i_Mute = 1'b0;
    i_Rst = 1'b0;
    cyc++;
  endtask

  // Monitor: every emitted sound must match the next expected one
  initial begin
    forever begin
      @(negedge i_Clk);
      #2;
      if (o_Sound_Cmd != 2'd0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_sound cyc=%0d got=%0d exp=none", cyc, o_Sound_Cmd);
        end else begin
          mon_s = sb.pop_front();
          if (mon_s.cmd != int'(o_Sound_Cmd) || mon_s.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL sound got cmd=%0d at cyc=%0d exp cmd=%0d at cyc=%0d",
                     o_Sound_Cmd, cyc, mon_s.cmd, mon_s.cyc);
          end
        end
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_sound cyc=%0d got=none exp cmd=%0d at cyc=%0d",
                 cyc, sb[0].cmd, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int drain;
    for (int l = 0; l < 4; l++) pcmd[l] = 0;
    doReset();
    idleCycles(3);

    $display("[TB] single request lane 2 MISS");
    raise(2, 3);
    idleCycles(30);

    $display("[TB] round robin, all lanes PERF");
    for (int l = 0; l < 4; l++) raise(l, 1);
    idleCycles(75);

    $display("[TB] overflow, six grants during first sound");
    raise(0, 2); raise(1, 1); raise(2, 3); raise(3, 2);
    idleCycles(4);
    raise(0, 1); raise(1, 3);
    idleCycles(110);

    $display("[TB] mute with queued entries");
    raise(3, 1);
    idleCycles(3);
    raise(0, 2); raise(1, 3); raise(2, 1);
    idleCycles(4);
    applyStimulus(1'b1);
    idleCycles(30);

    $display("[TB] zero-command request");
    raise(0, 0);
    idleCycles(6);
    pend[0] = 1'b0;
    for (int l = 0; l < 4; l++) raise(l, 2);
    idleCycles(70);

    $display("[TB] reset during PLAY with queued entries");
    raise(1, 3);
    idleCycles(4);
    raise(2, 1); raise(3, 2);
    idleCycles(3);
    doReset();
    idleCycles(30);
    raise(0, 1);
    idleCycles(25);

    $display("[TB] saturating drop counter");
    runRandom(400, 100, 0);

    $display("[TB] random traffic");
    runRandom(1500, 15, 3);

    pend = '0;
    drain = 0;
    while (cyc < free_at + 2 && drain < 200) begin
      applyStimulus(1'b0);
      drain++;
    end
    idleCycles(2);
    checkOutput("sounds_outstanding", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 The block SHALL have exactly one clock, i_Clk, and its reset SHALL be asynchronous and active-high, named i_Rst.
REQ-002 Parameters, one per line (name, default, meaning):
- DUR_PERF, 6_000_000, PLAY-state cycles after issuing cmd 1.
- DUR_GOOD, 4_500_000, PLAY-state cycles after issuing cmd 2.
- DUR_MISS, 8_000_000, PLAY-state cycles after issuing cmd 3.
- GAP_CYC, 250_000, silent cycles between sounds; 0 means the GAP state is skipped.
REQ-003 Ports, one per line (name, direction, width, meaning):
- i_Clk  in  1  50 MHz clock.
- i_Rst  in  1  async active-high reset.
- i_Req  in  4  per-lane request; held by the lane until acked.
- i_Req_Cmd  in  8  lane n command at bits [2n+1:2n]; 0=None, 1=Perf, 2=Good, 3=Miss.
- i_Mute  in  1  suppress and flush sounds.
- o_Ack  out  4  one-hot, combinational; the lane's request is consumed this cycle.
- o_Sound_Cmd  out  2  registered; nonzero for exactly one cycle per sound; drives the piezo driver's command input.
- o_Busy  out  1  registered; high in ISSUE, PLAY or GAP.
- o_Fifo_Cnt  out  3  registered; queued entries, 0..4.
- o_Drop_Cnt  out  8  registered; saturating count of commands lost because the FIFO was full.

Function
REQ-004 A lane SHALL be eligible iff i_Req[n]=1 and its command is nonzero; an ineligible lane SHALL never be acked.
REQ-005 Round-robin arbitration SHALL grant at most one eligible lane per cycle, searching from rr_ptr upward with wrap 3->0.
REQ-006 rr_ptr SHALL become (winner+1) mod 4 on any grant and SHALL hold otherwise.
REQ-007 The winner SHALL be acked in the same cycle regardless of FIFO state.
REQ-008 The winner SHALL be enqueued at the clock edge ending that cycle when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-009 A winner that is not enqueued SHALL increment o_Drop_Cnt, saturating at 255.
REQ-010 The FIFO SHALL have depth 4 and be first-in first-out.
REQ-011 A simultaneous push and pop SHALL leave o_Fifo_Cnt unchanged.
REQ-012 Pointers SHALL wrap modulo 4.
REQ-013 The FSM SHALL have four states: IDLE, ISSUE, PLAY, GAP.
REQ-014 From IDLE, the FSM SHALL go to ISSUE when o_Fifo_Cnt!=0 and i_Mute=0, and stay in IDLE otherwise.
REQ-015 In ISSUE (one cycle):
- o_Sound_Cmd SHALL equal the FIFO head.
- The head SHALL be popped.
- The timer SHALL be loaded with DUR_x for that command.
- The next state SHALL be PLAY.
REQ-016 PLAY SHALL last exactly DUR_x cycles, then go to GAP, or go to IDLE if GAP_CYC=0.
REQ-017 GAP SHALL last exactly GAP_CYC cycles, then go to IDLE.
REQ-018 o_Sound_Cmd SHALL be 0 in every state except ISSUE.
REQ-019 Latency: a request granted in cycle t into an empty FIFO while in IDLE SHALL produce a nonzero o_Sound_Cmd in cycle t+2.
REQ-020 When i_Mute=1:
- The FIFO SHALL be cleared each cycle.
- Grants SHALL still be acked and SHALL be discarded without counting as drops.
- PLAY/GAP in progress SHALL complete normally.
- ISSUE SHALL NOT be entered.
REQ-021 When i_Mute and a pop coincide, the FIFO SHALL end the cycle empty.
REQ-022 The timer SHALL be 23 bits wide, sized to DUR_MISS, and SHALL count down; parameters SHALL be at least 1 except GAP_CYC.

Reset
REQ-023 On i_Rst=1, immediately and independent of clock:
- FSM SHALL be in IDLE.
- rr_ptr, FIFO pointers and timer SHALL be 0.
- o_Sound_Cmd, o_Busy, o_Fifo_Cnt and o_Drop_Cnt SHALL be 0.
REQ-024 o_Ack SHALL be 0 while i_Rst=1.
REQ-025 Reset during PLAY SHALL abandon the sound and discard all queued commands; the first post-reset grant SHALL follow REQ-019.

Structure
REQ-026 Command codes (NONE/PERF/GOOD/MISS) and default DUR_*/GAP_CYC values SHALL live in a shared sound package/include, also used by the piezo driver.
REQ-027 The FIFO SHALL be a sub-module, sound_cmd_fifo, with push, pop, flush, data, count, full and empty.
REQ-028 Arbiter, FSM and drop counter SHALL reside in sound_scheduler.

Verification (DUR_PERF=12, DUR_GOOD=9, DUR_MISS=16, GAP_CYC=3)
REQ-029 Single request: lane 2 cmd 3 granted cycle 0 -> o_Ack=0100 in cycle 0; o_Sound_Cmd=3 in cycle 2 only; o_Busy high cycles 2..21; next ISSUE no earlier than cycle 23.
REQ-030 Round robin: all four lanes request cmd 1 from reset -> acks lane 0,1,2,3 in successive cycles; sounds issued in order 0,1,2,3, spaced 1+12+3+1=17 cycles.
REQ-031 Overflow: 6 grants while the first sound plays -> o_Fifo_Cnt=4; o_Drop_Cnt=1 (one entry already popped); exactly 5 sounds emitted.
REQ-032 Mute: 3 entries queued, assert i_Mute for 1 cycle -> o_Fifo_Cnt=0; no further o_Sound_Cmd; o_Drop_Cnt unchanged.
REQ-033 Reset mid-PLAY: assert i_Rst while in PLAY with 2 queued -> all outputs 0 asynchronously; no sound after release until a new request.
REQ-034 Zero-command request: i_Req=0001 with cmd 0 -> o_Ack=0; FIFO stays empty; rr_ptr unchanged.
